// File: rtl/vga_timing_if.sv
// Raster-scan output bundle: pixel coordinates, video/sync flags and frame strobes.
interface vga_timing_if;
   logic [9:0] x;
   logic [9:0] y;
   logic       active;
   logic       hsync;
   logic       vsync;
   logic       line_start;
   logic       frame_start;
   logic [7:0] frame_count;

   modport master (
      output x, y, active, hsync, vsync, line_start, frame_start, frame_count
   );

   modport slave (
      input x, y, active, hsync, vsync, line_start, frame_start, frame_count
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator; all outputs registered from the next-state counters.
// Optional macro VGA_TIMING_CE_EN adds a clock-enable input ce after rst.
module vga_timing_gen #(
   parameter int H_ACTIVE         = 640,
   parameter int H_FP             = 16,
   parameter int H_SYNC           = 96,
   parameter int H_BP             = 48,
   parameter int V_ACTIVE         = 480,
   parameter int V_FP             = 10,
   parameter int V_SYNC           = 2,
   parameter int V_BP             = 33,
   parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
`ifdef VGA_TIMING_CE_EN
   input  logic          ce,
`endif
   vga_timing_if.master  vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   // Range bounds kept 11 bits wide so an end bound of 1024 stays representable.
   localparam logic [10:0] H_ACT_E  = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT_E  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic        SYNC_ON  = SYNC_ACTIVE_HIGH ? 1'b1 : 1'b0;
   localparam logic        SYNC_OFF = ~SYNC_ON;

   logic       adv_s;
   logic [9:0] x_nxt_s;
   logic [9:0] y_nxt_s;
   logic       active_nxt_s;
   logic       hsync_nxt_s;
   logic       vsync_nxt_s;
   logic       line_start_nxt_s;
   logic       frame_start_nxt_s;

   logic [9:0] x_r;
   logic [9:0] y_r;
   logic       active_r;
   logic       hsync_r;
   logic       vsync_r;
   logic       line_start_r;
   logic       frame_start_r;
   logic [7:0] frame_count_r;

`ifdef VGA_TIMING_CE_EN
   assign adv_s = ce;
`else
   assign adv_s = 1'b1;
`endif

   // Next raster position: x wraps at end of line, y steps on each x wrap.
   always_comb begin
      x_nxt_s = x_r;
      y_nxt_s = y_r;
      if (x_r == H_LAST) begin
         x_nxt_s = 10'd0;
         if (y_r == V_LAST) begin
            y_nxt_s = 10'd0;
         end else begin
            y_nxt_s = y_r + 10'd1;
         end
      end else begin
         x_nxt_s = x_r + 10'd1;
      end
   end

   // Flags decoded from the next position so they align with the registered x/y.
   always_comb begin
      active_nxt_s      = ({1'b0, x_nxt_s} < H_ACT_E) && ({1'b0, y_nxt_s} < V_ACT_E);
      hsync_nxt_s       = SYNC_OFF;
      vsync_nxt_s       = SYNC_OFF;
      line_start_nxt_s  = (x_nxt_s == 10'd0);
      frame_start_nxt_s = (x_nxt_s == 10'd0) && (y_nxt_s == 10'd0);
      if (({1'b0, x_nxt_s} >= HS_BEG) && ({1'b0, x_nxt_s} < HS_END)) begin
         hsync_nxt_s = SYNC_ON;
      end else begin
         hsync_nxt_s = SYNC_OFF;
      end
      if (({1'b0, y_nxt_s} >= VS_BEG) && ({1'b0, y_nxt_s} < VS_END)) begin
         vsync_nxt_s = SYNC_ON;
      end else begin
         vsync_nxt_s = SYNC_OFF;
      end
   end

   // State and output registers; everything holds on non-advancing clocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_r           <= H_LAST;
         y_r           <= V_LAST;
         active_r      <= 1'b0;
         hsync_r       <= SYNC_OFF;
         vsync_r       <= SYNC_OFF;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
         frame_count_r <= 8'hFF;
      end else if (adv_s) begin
         x_r           <= x_nxt_s;
         y_r           <= y_nxt_s;
         active_r      <= active_nxt_s;
         hsync_r       <= hsync_nxt_s;
         vsync_r       <= vsync_nxt_s;
         line_start_r  <= line_start_nxt_s;
         frame_start_r <= frame_start_nxt_s;
         if (frame_start_nxt_s) begin
            frame_count_r <= frame_count_r + 8'd1;
         end
      end
   end

   assign vid.x           = x_r;
   assign vid.y           = y_r;
   assign vid.active      = active_r;
   assign vid.hsync       = hsync_r;
   assign vid.vsync       = vsync_r;
   assign vid.line_start  = line_start_r;
   assign vid.frame_start = frame_start_r;
   assign vid.frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a reduced-timing instance (active-high sync) and a default 640x480 instance
// are checked every cycle against an arithmetic raster model driven by a pixel-step counter.
module tb_vga_timing_gen;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       active;
      logic       hsync;
      logic       vsync;
      logic       line_start;
      logic       frame_start;
      logic [7:0] frame_count;
   } vid_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b1;

   int checks   = 0;
   int failures = 0;
   bit started  = 1'b0;

   vid_t q_small[$];
   vid_t q_dflt[$];

   vga_timing_if vif_small();
   vga_timing_if vif_dflt();

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_ACTIVE_HIGH(1'b1)
   ) u_small (
      .clk (clk),
      .rst (rst),
`ifdef VGA_TIMING_CE_EN
      .ce  (ce),
`endif
      .vid (vif_small.master)
   );

   vga_timing_gen u_dflt (
      .clk (clk),
      .rst (rst),
`ifdef VGA_TIMING_CE_EN
      .ce  (ce),
`endif
      .vid (vif_dflt.master)
   );

   // n = enabled pixel steps since reset release minus one (-1 while in reset).
   function automatic vid_t model(longint n, int ha, int hf, int hs, int hb,
                                  int va, int vf, int vs, int vb, bit pol);
      vid_t   e;
      longint ht, vt, pix, xx, yy;
      ht = longint'(ha + hf + hs + hb);
      vt = longint'(va + vf + vs + vb);
      if (n < 0) begin
         e.x           = 10'(ht - 1);
         e.y           = 10'(vt - 1);
         e.active      = 1'b0;
         e.hsync       = ~pol;
         e.vsync       = ~pol;
         e.line_start  = 1'b0;
         e.frame_start = 1'b0;
         e.frame_count = 8'hFF;
      end else begin
         pix = n % (ht * vt);
         xx  = pix % ht;
         yy  = pix / ht;
         e.x           = 10'(xx);
         e.y           = 10'(yy);
         e.active      = (xx < ha) && (yy < va);
         e.hsync       = ((xx >= ha + hf) && (xx < ha + hf + hs)) ? pol : ~pol;
         e.vsync       = ((yy >= va + vf) && (yy < va + vf + vs)) ? pol : ~pol;
         e.line_start  = (xx == 0);
         e.frame_start = (pix == 0);
         e.frame_count = 8'((n / (ht * vt)) % 256);
      end
      return e;
   endfunction

   function automatic vid_t sample(input logic [9:0] x, input logic [9:0] y,
                                   input logic a, input logic hs, input logic vs,
                                   input logic ls, input logic fs, input logic [7:0] fc);
      vid_t s;
      s = '{x: x, y: y, active: a, hsync: hs, vsync: vs,
            line_start: ls, frame_start: fs, frame_count: fc};
      return s;
   endfunction

   task automatic cmp(input string name, input vid_t act, input vid_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                  name, act.x, act.y, act.active, act.hsync, act.vsync, act.line_start,
                  act.frame_start, act.frame_count, exp.x, exp.y, exp.active, exp.hsync,
                  exp.vsync, exp.line_start, exp.frame_start, exp.frame_count);
      end
   endtask

   // Stimulus: long reset-free run (covers frame_count wrap), then random mid-frame resets.
   initial begin
      longint n = -1;
      int     hold = 0;
      int     p1;
      int     total;
      logic   r;
      logic   c;
`ifdef VGA_TIMING_CE_EN
      p1 = 52500;
`else
      p1 = 39300;
`endif
      total = p1 + 8000;
      for (int cyc = 0; cyc < total; cyc++) begin
         @(negedge clk);
         c = 1'b1;
`ifdef VGA_TIMING_CE_EN
         c = ($urandom_range(0, 3) != 0);
`endif
         if (cyc < 4) begin
            r = 1'b1;
         end else if (cyc < p1) begin
            r = 1'b0;
         end else if (hold > 0) begin
            r = 1'b1;
            hold--;
         end else if ($urandom_range(0, 299) == 0) begin
            r = 1'b1;
            hold = int'($urandom_range(0, 3));
         end else begin
            r = 1'b0;
         end
         rst = r;
         ce  = c;
         if (r) n = -1;
         else if (c) n = n + 1;
         q_small.push_back(model(n, 8, 2, 3, 2, 6, 1, 2, 1, 1'b1));
         q_dflt.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
         started = 1'b1;
      end
      @(posedge clk);
      #4;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Monitor: every cycle the DUTs present a pixel; pop and compare a little after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (started) begin
            if (q_small.size() == 0 || q_dflt.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL scoreboard_empty: got empty queue, want an expected entry");
            end else begin
               cmp("small", sample(vif_small.x, vif_small.y, vif_small.active, vif_small.hsync,
                                   vif_small.vsync, vif_small.line_start, vif_small.frame_start,
                                   vif_small.frame_count), q_small.pop_front());
               cmp("dflt", sample(vif_dflt.x, vif_dflt.y, vif_dflt.active, vif_dflt.hsync,
                                  vif_dflt.vsync, vif_dflt.line_start, vif_dflt.frame_start,
                                  vif_dflt.frame_count), q_dflt.pop_front());
            end
         end
      end
   end

endmodule
